// File: rtl/game_pkg.sv
// Shared types and constants for the game score/timer block.
package game_pkg;

   // Game phase; 2-bit encoding
   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      COUNTDOWN = 2'd1,
      PLAYING   = 2'd2,
      DONE      = 2'd3
   } state_t;

   localparam int              BCD_DIGITS = 4;
   localparam int              BCD_W      = 16;
   localparam logic [BCD_W-1:0] BCD_MAX   = 16'h9999;
   localparam logic [BCD_W-1:0] BCD_ZERO  = 16'h0000;

   // Extract one BCD digit (0 = units) from a packed 4-digit value
   function automatic logic [3:0] bcd_digit(input logic [BCD_W-1:0] v, input int idx);
      return v[idx*4 +: 4];
   endfunction

endpackage

// File: rtl/game_score_timer_bcd4_counter.sv
// 4-digit BCD register with load, saturating increment (stops at 9999)
// and floored decrement (stops at 0000). Load has priority over increment,
// increment over decrement.
module bcd4_counter
   import game_pkg::*;
#(
   parameter logic [BCD_W-1:0] RST_VAL = 16'h0000
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             i_load,
   input  logic [BCD_W-1:0] i_load_val,
   input  logic             i_inc,
   input  logic             i_dec,
   output logic [BCD_W-1:0] o_value
);

   logic [BCD_W-1:0]      r_value;
   logic [BCD_DIGITS-1:0] w_is9;
   logic [BCD_DIGITS-1:0] w_is0;
   logic [BCD_W-1:0]      w_inc_val;
   logic [BCD_W-1:0]      w_dec_val;
   logic                  w_at_max;
   logic                  w_at_zero;

   genvar gi;
   generate
      for (gi = 0; gi < BCD_DIGITS; gi++) begin : g_digit
         logic [3:0] w_d;
         logic       w_carry;
         logic       w_borrow;

         assign w_d       = bcd_digit(r_value, gi);
         assign w_is9[gi] = (w_d == 4'd9);
         assign w_is0[gi] = (w_d == 4'd0);

         // A digit moves on increment only when every lower digit is 9,
         // and on decrement only when every lower digit is 0.
         if (gi == 0) begin : g_lsd
            assign w_carry  = 1'b1;
            assign w_borrow = 1'b1;
         end else begin : g_upper
            assign w_carry  = &w_is9[gi-1:0];
            assign w_borrow = &w_is0[gi-1:0];
         end

         assign w_inc_val[gi*4 +: 4] = w_carry  ? (w_is9[gi] ? 4'd0 : w_d + 4'd1) : w_d;
         assign w_dec_val[gi*4 +: 4] = w_borrow ? (w_is0[gi] ? 4'd9 : w_d - 4'd1) : w_d;
      end
   endgenerate

   assign w_at_max  = (r_value == BCD_MAX);
   assign w_at_zero = (r_value == BCD_ZERO);

   // Value register: load, else saturating increment, else floored decrement
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_value <= RST_VAL;
      end else if (i_load) begin
         r_value <= i_load_val;
      end else if (i_inc && !w_at_max) begin
         r_value <= w_inc_val;
      end else if (i_dec && !w_at_zero) begin
         r_value <= w_dec_val;
      end
   end

   assign o_value = r_value;

endmodule

// File: rtl/game_score_timer.sv
// Game score/timer: pre-game BCD countdown, timed play phase accumulating
// hits into a saturating BCD score, then holds the final score.
// Optional feature macro: GAME_PAUSE_EN adds a 'pause' input that freezes
// the prescaler, ticks and hit counting during COUNTDOWN and PLAYING.
module game_score_timer
   import game_pkg::*;
#(
   parameter int               TICK_DIV   = 100000000,
   parameter logic [BCD_W-1:0] COUNT_INIT = 16'h0003,
   parameter logic [BCD_W-1:0] GAME_SECS  = 16'h0060
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             go,
   input  logic             hit,
`ifdef GAME_PAUSE_EN
   input  logic             pause,
`endif
   output logic             start,
   output logic [BCD_W-1:0] score,
   output logic [BCD_W-1:0] count,
   output logic             done
);

   localparam int               PRE_W    = $clog2(TICK_DIV);
   localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TICK_DIV - 1);

   state_t           r_state;
   logic [PRE_W-1:0] r_prescaler;
   logic             r_start;
   logic             r_done;

   logic             w_paused;
   logic             w_active;
   logic             w_run;
   logic             w_tick;
   logic             w_count_zero;
   logic             w_game_go;
   logic             w_cnt_load;
   logic [BCD_W-1:0] w_cnt_load_val;
   logic             w_cnt_dec;
   logic             w_score_inc;
   logic [BCD_W-1:0] w_count;
   logic [BCD_W-1:0] w_score;

`ifdef GAME_PAUSE_EN
   assign w_paused = pause;
`else
   assign w_paused = 1'b0;
`endif

   // Timekeeping only runs in the two timed phases, and freezes while paused
   assign w_active     = (r_state == COUNTDOWN) || (r_state == PLAYING);
   assign w_run        = w_active && !w_paused;
   assign w_tick       = w_run && (r_prescaler == PRE_LAST);
   assign w_count_zero = (w_count == BCD_ZERO);

   // A go is only honoured from IDLE or DONE; both start a fresh countdown
   assign w_game_go = go && ((r_state == IDLE) || (r_state == DONE));

   // Count register control: reload on game start / play entry, else tick down
   always_comb begin
      w_cnt_load     = 1'b0;
      w_cnt_load_val = COUNT_INIT;
      if (w_game_go) begin
         w_cnt_load     = 1'b1;
         w_cnt_load_val = COUNT_INIT;
      end else if ((r_state == COUNTDOWN) && w_tick && w_count_zero) begin
         w_cnt_load     = 1'b1;
         w_cnt_load_val = GAME_SECS;
      end
   end

   assign w_cnt_dec   = w_tick && !w_count_zero;
   assign w_score_inc = (r_state == PLAYING) && hit && !w_paused;

   bcd4_counter #(
      .RST_VAL (COUNT_INIT)
   ) u_count (
      .clock      (clock),
      .reset      (reset),
      .i_load     (w_cnt_load),
      .i_load_val (w_cnt_load_val),
      .i_inc      (1'b0),
      .i_dec      (w_cnt_dec),
      .o_value    (w_count)
   );

   bcd4_counter #(
      .RST_VAL (BCD_ZERO)
   ) u_score (
      .clock      (clock),
      .reset      (reset),
      .i_load     (w_game_go),
      .i_load_val (BCD_ZERO),
      .i_inc      (w_score_inc),
      .i_dec      (1'b0),
      .o_value    (w_score)
   );

   // Phase FSM with prescaler and registered start/done flags
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_state     <= IDLE;
         r_prescaler <= '0;
         r_start     <= 1'b0;
         r_done      <= 1'b0;
      end else begin
         if (w_run) begin
            r_prescaler <= w_tick ? '0 : r_prescaler + PRE_W'(1);
         end
         case (r_state)
            IDLE: begin
               r_start <= 1'b0;
               r_done  <= 1'b0;
               if (go) begin
                  r_state     <= COUNTDOWN;
                  r_prescaler <= '0;
               end
            end
            COUNTDOWN: begin
               // count has already shown 0000 for a full tick when we leave
               if (w_tick && w_count_zero) begin
                  r_state     <= PLAYING;
                  r_start     <= 1'b1;
                  r_prescaler <= '0;
               end
            end
            PLAYING: begin
               if (w_tick && w_count_zero) begin
                  r_state     <= DONE;
                  r_done      <= 1'b1;
                  r_prescaler <= '0;
               end
            end
            DONE: begin
               if (go) begin
                  r_state     <= COUNTDOWN;
                  r_start     <= 1'b0;
                  r_done      <= 1'b0;
                  r_prescaler <= '0;
               end
            end
            default: begin
               r_state     <= IDLE;
               r_start     <= 1'b0;
               r_done      <= 1'b0;
               r_prescaler <= '0;
            end
         endcase
      end
   end

   assign start = r_start;
   assign done  = r_done;
   assign count = w_count;
   assign score = w_score;

endmodule

// File: tb/tb_game_score_timer.sv
// Randomized self-checking bench for game_score_timer with an integer-level
// reference model (decimal seconds/score converted to BCD for comparison).
module tb_game_score_timer;

   localparam int TB_TICK   = 4;
   localparam int INIT_DEC  = 3;
   localparam int GAME_DEC  = 12;

   logic        clock;
   logic        reset;
   logic        go, hit;
   logic        start, done;
   logic [15:0] score, count;

   logic        go2, hit2;
   logic        start2, done2;
   logic [15:0] score2, count2;

   int n_checks = 0;
   int n_errors = 0;

   // reference model state: phase 0=idle 1=countdown 2=playing 3=done
   int m_phase;
   int m_cyc;     // cycles elapsed inside the current timed second
   int m_secs;    // seconds remaining, decimal
   int m_score;   // hits, decimal

   game_score_timer #(
      .TICK_DIV   (TB_TICK),
      .COUNT_INIT (16'h0003),
      .GAME_SECS  (16'h0012)
   ) dut (
      .clock (clock),
      .reset (reset),
      .go    (go),
      .hit   (hit),
`ifdef GAME_PAUSE_EN
      .pause (1'b0),
`endif
      .start (start),
      .score (score),
      .count (count),
      .done  (done)
   );

   // long play phase so the score can be driven to saturation
   game_score_timer #(
      .TICK_DIV   (1024),
      .COUNT_INIT (16'h0001),
      .GAME_SECS  (16'h0012)
   ) dut_sat (
      .clock (clock),
      .reset (reset),
      .go    (go2),
      .hit   (hit2),
`ifdef GAME_PAUSE_EN
      .pause (1'b0),
`endif
      .start (start2),
      .score (score2),
      .count (count2),
      .done  (done2)
   );

   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   function automatic logic [15:0] to_bcd(input int v);
      return {4'((v / 1000) % 10), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
   endfunction

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic model_reset();
      m_phase = 0;
      m_cyc   = 0;
      m_secs  = INIT_DEC;
      m_score = 0;
   endtask

   // One clock edge of game rules, in seconds and hit counts
   task automatic model_step(input logic g, input logic h);
      bit second_ends;
      second_ends = (m_phase == 1 || m_phase == 2) && (m_cyc == TB_TICK - 1);
      case (m_phase)
         0, 3: begin
            if (g) begin
               m_phase = 1; m_cyc = 0; m_secs = INIT_DEC; m_score = 0;
            end
         end
         1: begin
            m_cyc = second_ends ? 0 : m_cyc + 1;
            if (second_ends) begin
               if (m_secs > 0) m_secs--;
               else begin m_phase = 2; m_secs = GAME_DEC; end
            end
         end
         default: begin
            m_cyc = second_ends ? 0 : m_cyc + 1;
            if (h && m_score < 9999) m_score++;
            if (second_ends) begin
               if (m_secs > 0) m_secs--;
               else m_phase = 3;
            end
         end
      endcase
   endtask

   task automatic check_all();
      check_eq("start", 32'(start), 32'(m_phase >= 2));
      check_eq("done",  32'(done),  32'(m_phase == 3));
      check_eq("count", 32'(count), 32'(to_bcd(m_secs)));
      check_eq("score", 32'(score), 32'(to_bcd(m_score)));
      $display("t=%0t go=%0b hit=%0b start=%0b done=%0b count=%h score=%h",
               $time, go, hit, start, done, count, score);
   endtask

   // Apply inputs for one cycle (called at posedge+1), then check at posedge+1
   task automatic cycle(input logic g, input logic h);
      go  = g;
      hit = h;
      @(posedge clock);
      model_step(g, h);
      #1;
      check_all();
   endtask

   task automatic run_until_phase(input int ph, input int budget, input bit rand_hits);
      int k;
      k = 0;
      while (m_phase != ph && k < budget) begin
         cycle(1'b0, rand_hits ? ($urandom_range(0, 2) == 0) : 1'b0);
         k++;
      end
      if (m_phase != ph) begin
         n_checks++;
         n_errors++;
         $display("FAIL wait_phase: got phase %0d required %0d", m_phase, ph);
      end
   endtask

   initial begin
      int n;
      bit seen;
      reset = 1'b1; go = 1'b0; hit = 1'b0; go2 = 1'b0; hit2 = 1'b0;
      model_reset();
      #12;
      check_eq("rst_start", 32'(start), 32'd0);
      check_eq("rst_done",  32'(done),  32'd0);
      check_eq("rst_count", 32'(count), 32'h0003);
      check_eq("rst_score", 32'(score), 32'h0000);
      @(posedge clock);
      #1 reset = 1'b0;

      // idle: nothing moves, hits ignored
      for (int i = 0; i < 50; i++) cycle(1'b0, $urandom_range(0, 1) == 1);

      // randomized games, including ignored go during play
      cycle(1'b1, 1'b0);
      for (int i = 0; i < 300; i++)
         cycle($urandom_range(0, 24) == 0, $urandom_range(0, 2) == 0);

      // directed game: 5 hits, hit on the final tick, restart
      run_until_phase(3, 200, 1'b0);
      cycle(1'b1, 1'b0);
      run_until_phase(2, 100, 1'b0);
      for (int i = 0; i < 5; i++) cycle(1'b0, 1'b1);
      check_eq("five_hits", 32'(score), 32'h0005);
      n = 0;
      while (m_phase != 3 && n < 200) begin
         cycle(1'b0, m_phase == 2 && m_cyc == TB_TICK - 1 && m_secs == 0);
         n++;
      end
      check_eq("final_hit_score", 32'(score), 32'h0006);
      check_eq("final_done",      32'(done),  32'd1);
      check_eq("final_start",     32'(start), 32'd1);
      check_eq("final_count",     32'(count), 32'h0000);
      for (int i = 0; i < 5; i++) cycle(1'b0, 1'b1);
      check_eq("done_hit_ignored", 32'(score), 32'h0006);
      cycle(1'b1, 1'b0);
      check_eq("restart_score", 32'(score), 32'h0000);
      check_eq("restart_count", 32'(count), 32'h0003);
      check_eq("restart_start", 32'(start), 32'd0);
      check_eq("restart_done",  32'(done),  32'd0);

      // reset in the middle of play, observed before the next edge
      run_until_phase(2, 100, 1'b0);
      for (int i = 0; i < 7; i++) cycle(1'b0, 1'b1);
      check_eq("seven_hits", 32'(score), 32'h0007);
      reset = 1'b1;
      #1;
      check_eq("async_start", 32'(start), 32'd0);
      check_eq("async_done",  32'(done),  32'd0);
      check_eq("async_count", 32'(count), 32'h0003);
      check_eq("async_score", 32'(score), 32'h0000);
      model_reset();
      @(posedge clock);
      #1 reset = 1'b0;
      for (int i = 0; i < 10; i++) cycle(1'b0, 1'b1);

      // score saturation on the long-game instance
      go2 = 1'b1;
      @(posedge clock);
      #1 go2 = 1'b0;
      seen = 1'b0;
      for (int i = 0; i < 5000 && !seen; i++) begin
         @(posedge clock);
         #1;
         if (start2) seen = 1'b1;
      end
      check_eq("sat_reached_play", 32'(start2), 32'd1);
      hit2 = 1'b1;
      for (int k = 1; k <= 10001; k++) begin
         @(posedge clock);
         #1;
         if (k <= 5 || k % 2000 == 0 || k >= 9998) begin
            check_eq("sat_score", 32'(score2), 32'(to_bcd(k > 9999 ? 9999 : k)));
            $display("sat hits=%0d score=%h", k, score2);
         end
      end
      hit2 = 1'b0;
      @(posedge clock);
      #1;
      check_eq("sat_hold",  32'(score2), 32'h9999);
      check_eq("sat_done",  32'(done2),  32'd0);
      check_eq("sat_start", 32'(start2), 32'd1);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/game_score_timer.md
Name: game_score_timer

Overview:
- Produces the values that the seven-segment display multiplexer shows: `count` (4-digit BCD), `score` (4-digit BCD) and `start`, which selects score over count.
- Runs a pre-game countdown, then a timed play phase that accumulates hits into a saturating BCD score, then holds the final score.
- Sits between the game-input logic (`go`/`hit` pulses) and the display mux.

Parameters:
- TICK_DIV, 100000000, clock cycles per one-second tick; legal range 2..2^27.
- COUNT_INIT, 16'h0003, pre-game countdown start value; 4-digit BCD, nonzero, valid BCD.
- GAME_SECS, 16'h0060, play-phase length in seconds; 4-digit BCD, nonzero, valid BCD.

Ports:
- clock  input  1  system clock
- reset  input  1  asynchronous, active-high reset
- go  input  1  single-cycle request to begin or restart a game
- hit  input  1  single-cycle scoring event
- start  output  1  1 = display score, 0 = display count
- score  output  16  4-digit BCD score; [15:12] is the thousands digit
- count  output  16  4-digit BCD countdown or remaining game time
- done  output  1  high while the game is over

Behaviour:
- All outputs are registered. Reset is asynchronous and active-high.
- Reset values: state=IDLE, start=0, done=0, score=16'h0000, count=COUNT_INIT, prescaler=0.
- Prescaler:
  - Counts 0..TICK_DIV-1 only in COUNTDOWN and PLAYING.
  - `tick` is an internal 1-cycle strobe asserted in the cycle the prescaler equals TICK_DIV-1; the prescaler then wraps to 0.
  - The prescaler is cleared to 0 on every state entry.
- States:
  - IDLE: start=0, done=0, count=COUNT_INIT. `go` -> COUNTDOWN on the next edge; score cleared to 0. `hit` is ignored.
  - COUNTDOWN: start=0. On `tick` with count!=0, count = count-1 in BCD, with per-digit borrow (e.g. 0010->0009). On `tick` with count==0, go to PLAYING, load count=GAME_SECS, and set start=1 on the same edge. The display therefore shows 0000 for one full tick. `go` and `hit` are ignored.
  - PLAYING: start=1. On `hit`, score = score+1 in BCD with carry; at 9999 it stays 9999 (saturates, no wrap). On `tick` with count!=0, count decrements in BCD. On `tick` with count==0, go to DONE. `go` is ignored.
  - DONE: start=1 so the final score stays visible; done=1; count=0000. `hit` is ignored. `go` -> COUNTDOWN, with score cleared to 0, count=COUNT_INIT, start=0 and done=0 on the same edge.
- Simultaneous events:
  - `hit` and `tick` in the same PLAYING cycle both take effect.
  - A `hit` in the cycle that transitions PLAYING->DONE is counted.
- Latency: `go` -> start/count change visible 1 cycle later. `hit` -> score updated 1 cycle later.
- Reset mid-game returns immediately to the reset values; no partial score is retained.
- `go` or `hit` held high for multiple cycles is treated as one event per cycle. Callers supply single-cycle pulses.

Optional Feature:
- Macro: GAME_PAUSE_EN.
- Defined:
  - Adds input port `pause` (1 bit).
  - While pause=1 in COUNTDOWN or PLAYING, the prescaler holds its value, no ticks occur, and `hit` is ignored.
  - State, count and score hold.
  - Releasing pause resumes from the held prescaler value.
  - `pause` has no effect in IDLE or DONE.
- Undefined: no `pause` port; behaviour is exactly as above.

Decomposition:
- Package game_pkg holds:
  - the state enum (IDLE, COUNTDOWN, PLAYING, DONE; 2-bit encoding)
  - BCD_DIGITS=4 and BCD_W=16 constants
  - BCD_MAX=16'h9999
- Sub-module bcd4_counter: 4-digit BCD register with load, increment (saturating at 9999) and decrement (stops at 0000). It is instantiated twice, once for score and once for count. The top level keeps the FSM and the prescaler.

Test Plan:
- Run with TICK_DIV=4, COUNT_INIT=16'h0003, GAME_SECS=16'h0012.
- Reset then idle -> start=0, done=0, count=0003, score=0000; no change over 50 cycles.
- Pulse go -> count steps 0003,0002,0001,0000 every 4 cycles. After the next tick: start=1, count=0012, done=0.
- Decrement across a digit boundary: in PLAYING, count 0012 -> 0011 -> 0010 -> 0009 at successive ticks.
- 5 hit pulses in PLAYING -> score=0005. Preload via 9999+1 hits (or force) -> score stays 9999 after an extra hit.
- Hit coincident with the final tick -> DONE with score incremented; start=1, done=1. Later hits are ignored. Then go -> score=0000, count=0003, start=0, done=0.
- Assert reset in the middle of PLAYING with score=0007 -> all outputs return to reset values immediately, asynchronously, before the next clock edge.
